// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: I2S master transmitter. Buffers one stereo pair behind a
// valid/ready handshake. Derives BCLK/LRCLK from clk and shifts each pair out
// MSB-first in standard I2S framing, with the MSB one BCLK after the LRCLK edge.
module i2s_tx_serializer #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_left,
    input  logic [DATA_W-1:0] sample_right,
    output logic              sample_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdout,
    output logic              frame_start,
    output logic              underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(BCLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] IDX_RIGHT = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] L_FIRST   = BIT_W'(1);
    localparam logic [BIT_W-1:0] L_LAST    = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] R_FIRST   = BIT_W'(SLOT_W + 1);
    localparam logic [BIT_W-1:0] R_LAST    = BIT_W'(SLOT_W + DATA_W);

    // Holding register (one stereo pair waiting for the next frame)
    logic              hold_full_q,  hold_full_d;
    logic [DATA_W-1:0] hold_left_q,  hold_left_d;
    logic [DATA_W-1:0] hold_right_q, hold_right_d;

    // Serial clock generation and frame position
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic              bclk_q,  bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdout_q, sdout_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q,    underrun_d;

    // Frame registers double as shift registers: the MSB is always the next bit out
    logic [DATA_W-1:0] frame_left_q,  frame_left_d;
    logic [DATA_W-1:0] frame_right_q, frame_right_d;

    logic accept;

    // Next-state logic: handshake, BCLK divider, shift events and frame loads
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        hold_full_d   = hold_full_q;
        hold_left_d   = hold_left_q;
        hold_right_d  = hold_right_q;
        div_cnt_d     = div_cnt_q;
        bit_idx_d     = bit_idx_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        sdout_d       = sdout_q;
        frame_left_d  = frame_left_q;
        frame_right_d = frame_right_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        // Acceptance ignores enable; a pair taken in the same clk as a frame
        // load only fills the hold register and waits for the following frame.
        accept = sample_valid && !hold_full_q;
        if (accept) begin
            hold_full_d  = 1'b1;
            hold_left_d  = sample_left;
            hold_right_d = sample_right;
        end

        if (!enable) begin
            div_cnt_d     = '0;
            bit_idx_d     = IDX_LAST;
            bclk_d        = 1'b0;
            lrclk_d       = 1'b0;
            sdout_d       = 1'b0;
            frame_left_d  = '0;
            frame_right_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = !bclk_q;
            // A falling BCLK is a shift event: advance the bit position and
            // update lrclk/sdout together.
            if (bclk_q) begin
                bit_idx_d = (bit_idx_q == IDX_LAST) ? '0 : bit_idx_q + BIT_W'(1);
                lrclk_d   = (bit_idx_d >= IDX_RIGHT);
                sdout_d   = 1'b0;
                if (bit_idx_d == '0) begin
                    frame_start_d = 1'b1;
                    if (hold_full_q) begin
                        frame_left_d  = hold_left_q;
                        frame_right_d = hold_right_q;
                        hold_full_d   = 1'b0;
                    end else begin
                        frame_left_d  = '0;
                        frame_right_d = '0;
                        underrun_d    = 1'b1;
                    end
                end else if (bit_idx_d >= L_FIRST && bit_idx_d <= L_LAST) begin
                    sdout_d      = frame_left_q[DATA_W-1];
                    frame_left_d = frame_left_q << 1;
                end else if (bit_idx_d >= R_FIRST && bit_idx_d <= R_LAST) begin
                    sdout_d       = frame_right_q[DATA_W-1];
                    frame_right_d = frame_right_q << 1;
                end
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // State register: reset clears everything, including the held pair
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full_q   <= 1'b0;
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            div_cnt_q     <= '0;
            bit_idx_q     <= IDX_LAST;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdout_q       <= 1'b0;
            frame_left_q  <= '0;
            frame_right_q <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            hold_full_q   <= hold_full_d;
            hold_left_q   <= hold_left_d;
            hold_right_q  <= hold_right_d;
            div_cnt_q     <= div_cnt_d;
            bit_idx_q     <= bit_idx_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdout_q       <= sdout_d;
            frame_left_q  <= frame_left_d;
            frame_right_q <= frame_right_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdout        = sdout_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: directed sequence with random sample data, checked
// every clk against an arithmetic model of the I2S frame timing.
module tb_i2s_tx_serializer;

    localparam int DATA_W     = 24;
    localparam int SLOT_W     = 32;
    localparam int BCLK_DIV   = 4;
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int FRAME_CLKS = 2 * BCLK_DIV * FRAME_BITS;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              sample_ready;
    logic              bclk;
    logic              lrclk;
    logic              sdout;
    logic              frame_start;
    logic              underrun;

    i2s_tx_serializer #(
        .DATA_W   (DATA_W),
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdout        (sdout),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int                m_k;          // clk edges since enable took effect
    bit                m_hold_full;
    logic [DATA_W-1:0] m_hold_l, m_hold_r;
    logic [DATA_W-1:0] m_frame_l, m_frame_r;
    bit                m_bclk, m_lrclk, m_sdout, m_fs, m_ur;

    // Serial capture built purely from observed DUT pins
    int                cap_b = -1;
    logic [DATA_W-1:0] cap_l, cap_r;
    logic              prev_bclk = 1'b0;
    logic              prev_lr   = 1'b0;
    int                lr_rises  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Bit b of a frame in I2S format: MSB one bit after each slot starts
    function automatic bit ref_bit(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                                   input int b);
        logic [DATA_W-1:0] t;
        if (b >= 1 && b <= DATA_W) begin
            t = l >> (DATA_W - b);
            return t[0];
        end
        if (b >= SLOT_W + 1 && b <= SLOT_W + DATA_W) begin
            t = r >> (DATA_W - (b - SLOT_W));
            return t[0];
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_k = 0; m_hold_full = 1'b0; m_hold_l = '0; m_hold_r = '0;
        m_frame_l = '0; m_frame_r = '0;
        m_bclk = 1'b0; m_lrclk = 1'b0; m_sdout = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
    endtask

    // One clk edge of the model, from the inputs present at that edge
    task automatic model_edge();
        bit accept;
        int b;
        accept = sample_valid && !m_hold_full;
        m_fs = 1'b0;
        m_ur = 1'b0;
        if (!enable) begin
            m_k = 0; m_bclk = 1'b0; m_lrclk = 1'b0; m_sdout = 1'b0;
            m_frame_l = '0; m_frame_r = '0;
        end else begin
            m_k++;
            m_bclk = ((m_k / BCLK_DIV) % 2) == 1;
            if (m_k % (2 * BCLK_DIV) == 0) begin
                b = (m_k / (2 * BCLK_DIV) - 1) % FRAME_BITS;
                if (b == 0) begin
                    m_fs = 1'b1;
                    if (m_hold_full) begin
                        m_frame_l = m_hold_l; m_frame_r = m_hold_r; m_hold_full = 1'b0;
                    end else begin
                        m_frame_l = '0; m_frame_r = '0; m_ur = 1'b1;
                    end
                end
                m_lrclk = (b >= SLOT_W);
                m_sdout = ref_bit(m_frame_l, m_frame_r, b);
            end
        end
        if (accept) begin
            m_hold_full = 1'b1; m_hold_l = sample_left; m_hold_r = sample_right;
        end
    endtask

    task automatic check_outputs();
        check("sample_ready", 32'(sample_ready), 32'(!m_hold_full));
        check("bclk",         32'(bclk),         32'(m_bclk));
        check("lrclk",        32'(lrclk),        32'(m_lrclk));
        check("sdout",        32'(sdout),        32'(m_sdout));
        check("frame_start",  32'(frame_start),  32'(m_fs));
        check("underrun",     32'(underrun),     32'(m_ur));
    endtask

    // Advance one clk, update the model, compare #1 after the edge, capture pins
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_outputs();
        if (frame_start) begin
            cap_b = 0; cap_l = '0; cap_r = '0;
        end else if (prev_bclk && !bclk && cap_b >= 0) begin
            cap_b++;
            if (cap_b >= 1 && cap_b <= DATA_W) cap_l = (cap_l << 1) | DATA_W'(sdout);
            if (cap_b >= SLOT_W + 1 && cap_b <= SLOT_W + DATA_W) cap_r = (cap_r << 1) | DATA_W'(sdout);
        end
        if (!prev_lr && lrclk) lr_rises++;
        prev_bclk = bclk;
        prev_lr   = lrclk;
    endtask

    // Run until frame_start; returns the enable-relative edge count or -1
    task automatic wait_fs(input int limit, output int at_k);
        at_k = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (frame_start) begin
                at_k = m_k;
                break;
            end
        end
    endtask

    int                fs_k;
    int                fs_cnt, ur_cnt, acc_cnt;
    logic              ready_before;
    logic [DATA_W-1:0] held_l, held_r;

    initial begin
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        sample_left = '0; sample_right = '0;
        model_reset();
        #1;
        check_outputs();

        // Reset and idle: no bclk activity, sample_ready high
        repeat (20) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("idle_no_frame", 32'(cap_b), 32'(-1));

        // Known pair, enable with it: frame_start at clk 8, then one full frame
        enable = 1'b1; sample_valid = 1'b1;
        sample_left = 24'hA5A5A5; sample_right = 24'h123456;
        tick();
        sample_valid = 1'b0;
        wait_fs(40, fs_k);
        check("first_fs_clk", 32'(fs_k), 32'd8);
        check("first_fs_no_underrun", 32'(underrun), 32'd0);
        lr_rises = 0;
        repeat (FRAME_CLKS - 1) tick();
        check("left_word", 32'(cap_l), 32'h00A5A5A5);
        check("right_word", 32'(cap_r), 32'h00123456);
        check("bits_in_frame", 32'(cap_b), 32'(FRAME_BITS - 1));
        check("lrclk_rises", 32'(lr_rises), 32'd1);

        // Nothing offered: underrun frame of zeros, lrclk still toggles
        tick();
        check("underrun_fs", 32'(frame_start), 32'd1);
        check("underrun_pulse", 32'(underrun), 32'd1);
        lr_rises = 0;
        repeat (FRAME_CLKS - 1) tick();
        check("underrun_left_zero", 32'(cap_l), 32'd0);
        check("underrun_right_zero", 32'(cap_r), 32'd0);
        check("underrun_lrclk_rises", 32'(lr_rises), 32'd1);

        // Streaming: offer lands on a frame-load clk (no bypass), then one pair per frame
        sample_valid = 1'b1;
        sample_left = DATA_W'($urandom); sample_right = DATA_W'($urandom);
        tick();
        check("same_clk_no_bypass", 32'(underrun), 32'd1);
        check("ready_low_after_accept", 32'(sample_ready), 32'd0);
        sample_left = DATA_W'($urandom); sample_right = DATA_W'($urandom);
        fs_cnt = 0; ur_cnt = 0; acc_cnt = 0;
        for (int i = 0; i < 4 * FRAME_CLKS + 50; i++) begin
            ready_before = sample_ready;
            tick();
            if (frame_start) fs_cnt++;
            if (underrun) ur_cnt++;
            if (ready_before) begin
                acc_cnt++;
                held_l = sample_left; held_r = sample_right;
                sample_left = DATA_W'($urandom); sample_right = DATA_W'($urandom);
            end
        end
        sample_valid = 1'b0;
        check("stream_frames", 32'(fs_cnt), 32'd4);
        check("stream_accepts", 32'(acc_cnt), 32'd4);
        check("stream_underruns", 32'(ur_cnt), 32'd0);

        // Drop enable mid-right-slot with a pair held, then re-enable
        for (int i = 0; i < FRAME_CLKS && !lrclk; i++) tick();
        repeat (10) tick();
        check("in_right_slot", 32'(lrclk), 32'd1);
        enable = 1'b0;
        tick();
        check("disable_bclk", 32'(bclk), 32'd0);
        check("disable_lrclk", 32'(lrclk), 32'd0);
        check("disable_sdout", 32'(sdout), 32'd0);
        repeat (20) tick();
        check("hold_retained", 32'(sample_ready), 32'd0);
        enable = 1'b1;
        wait_fs(40, fs_k);
        check("reenable_fs_clk", 32'(fs_k), 32'd8);
        repeat (FRAME_CLKS - 1) tick();
        check("reenable_left", 32'(cap_l), 32'(held_l));
        check("reenable_right", 32'(cap_r), 32'(held_r));

        // Random valid/data traffic over a few frames
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            sample_valid = 1'($urandom_range(0, 1));
            sample_left  = DATA_W'($urandom);
            sample_right = DATA_W'($urandom);
            tick();
        end
        sample_valid = 1'b0;

        // Reset mid-frame with a pair held: outputs clear at once, pair discarded
        wait_fs(FRAME_CLKS + 10, fs_k);
        sample_valid = 1'b1;
        held_l = DATA_W'($urandom) | DATA_W'(1); held_r = DATA_W'($urandom) | DATA_W'(1);
        sample_left = held_l; sample_right = held_r;
        tick();
        sample_valid = 1'b0;
        repeat (100) tick();
        check("held_before_reset", 32'(sample_ready), 32'd0);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check("async_reset_ready", 32'(sample_ready), 32'd1);
        repeat (3) tick();
        reset = 1'b0;
        wait_fs(40, fs_k);
        check("post_reset_fs_clk", 32'(fs_k), 32'd8);
        check("post_reset_underrun", 32'(underrun), 32'd1);
        repeat (FRAME_CLKS - 1) tick();
        check("discarded_left", 32'(cap_l), 32'd0);
        check("discarded_right", 32'(cap_r), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Downstream I2S master transmitter for the audio path. It accepts parallel stereo samples (left/right, DATA_W bits each) over a valid/ready handshake and buffers one stereo pair. It generates BCLK and LRCLK from the system clock and serializes the samples MSB-first in standard I2S format (MSB one BCLK after the LRCLK edge) toward the codec DAC. It is the playback-side counterpart of the I2S capture controller and consumes the processed samples that the controller's downstream DSP produces.

## Interface
- DATA_W, 24, sample width per channel; must satisfy 1 ≤ DATA_W < SLOT_W
- SLOT_W, 32, BCLK periods per channel slot; frame = 2*SLOT_W bits
- BCLK_DIV, 4, clk cycles per BCLK half-period; must be ≥ 2
- clk  in  1  system clock, single clock domain
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run the serial clocks; low = idle/flush
- sample_valid  in  1  left/right pair valid
- sample_left  in  DATA_W  left-channel sample, two's complement
- sample_right  in  DATA_W  right-channel sample
- sample_ready  out  1  holding register empty; reset 1
- bclk  out  1  bit clock, registered; reset 0
- lrclk  out  1  word select, 0 = left, 1 = right; registered; reset 0
- sdout  out  1  serial data, changes only on BCLK falling transitions; reset 0
- frame_start  out  1  one-clk pulse when a new frame is loaded; reset 0
- underrun  out  1  one-clk pulse, coincident with frame_start, when no sample was held; reset 0

## Operation
- Holding register: one stereo pair plus hold_full flag. `sample_ready = !hold_full`. Accept on `sample_valid && sample_ready`, which sets hold_full. Acceptance is independent of enable.
- Divider: div_cnt counts 0..BCLK_DIV-1 while enable=1. At BCLK_DIV-1 it wraps and bclk toggles. A 1→0 toggle is a *shift event*.
- bit_idx: 0..2*SLOT_W-1, reset value 2*SLOT_W-1. It increments (wraps) on each shift event.
- At a shift event that takes bit_idx to 0 (frame load):
  - If hold_full: frame registers ← held pair, hold_full cleared, frame_start = 1.
  - Else: frame registers ← 0, frame_start = 1, underrun = 1.
  - A sample accepted in the same clk is not bypassed; it lands in the hold register for the next frame.
- At each shift event, with new index b:
  - `lrclk ← (b ≥ SLOT_W)`.
  - sdout ← left[DATA_W-b] for 1 ≤ b ≤ DATA_W.
  - sdout ← right[DATA_W-(b-SLOT_W)] for SLOT_W+1 ≤ b ≤ SLOT_W+DATA_W.
  - sdout ← 0 otherwise (bit 0, bit SLOT_W, padding).
- enable=0 (from the next clk, including mid-frame):
  - div_cnt=0, bclk=0, lrclk=0, sdout=0, bit_idx=2*SLOT_W-1, frame registers cleared.
  - No frame_start or underrun pulses.
  - Hold register contents retained.
- Reset (any time): all state returns to reset values immediately; held sample discarded; sample_ready=1.

## Timing
- bclk period = 2*BCLK_DIV clks; frame = 4*SLOT_W*BCLK_DIV clks (512 clks with defaults).
- With enable held high after reset release:
  - first bclk rise at the clk edge ending cycle BCLK_DIV;
  - first shift event (frame load, bit_idx=0) at cycle 2*BCLK_DIV.
- bclk, lrclk, sdout, frame_start and underrun update on the same clk edge as the shift event. The receiver samples sdout on the following bclk rise.
- sample_ready falls the clk after acceptance. It rises the clk after the frame load that consumes the pair.
- Maximum sustained input rate: one pair per frame. Earlier offers stall on sample_ready=0.

## Test plan
- Reset with enable=0 → sample_ready=1; bclk, lrclk, sdout, frame_start, underrun all 0; no bclk activity.
- Offer left=0xA5A5A5, right=0x123456 with enable=1 (defaults) → frame_start at clk 8. Then:
  - lrclk=0 for 32 bclk; sdout bits 1..24 = 0xA5A5A5 MSB-first; bits 25..31 = 0.
  - lrclk=1; bits 33..56 = 0x123456; remainder 0.
- Hold valid high with a new pair each accept → one accept per 512 clks; sample_ready low between accepts; no underrun after the first frame.
- No sample offered at a frame boundary → frame_start and underrun pulse together for one clk; sdout all zeros for that frame; lrclk keeps toggling.
- Drop enable mid-right-slot → next clk bclk, lrclk, sdout = 0. Re-enable → first frame_start 8 clks later, starting with the still-held pair.
- Assert reset mid-frame with a pair held → outputs to reset values asynchronously; sample_ready=1; the held pair is never transmitted.
